// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between one icache and one dcache
//
// Grants the RAM port to the icache fill request or the dcache read/write request,
// one at a time. Arbitration is registered (IDLE -> grant takes one cycle) and
// alternates on contention. A watchdog raises a sticky err when a grant waits too long.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   iREN, iaddr          icache fill request and word address
//   dREN, dWEN, daddr,   dcache read/write request, word address, write data
//   dstore
//   iwait, iload         icache handshake: iwait low for one cycle on completion
//   dwait, dload         dcache handshake: dwait low for one cycle on completion
//   ramREN, ramWEN,      RAM strobes, address and write data
//   ramaddr, ramstore
//   ramload, ramstate    RAM read data and status (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
//   err                  sticky watchdog flag
module mem_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int              CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [1:0]      RAM_ACCESS  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  logic          d_req;
  logic          ram_access;
  logic [CW-1:0] wd_inc;

  assign d_req      = dREN | dWEN;
  assign ram_access = (ramstate == RAM_ACCESS);
  assign err        = err_q;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;

    // Saturating increment so a stuck RAM cannot wrap the counter back below TIMEOUT.
    wd_inc = (wd_cnt_q == TIMEOUT_CNT) ? wd_cnt_q : wd_cnt_q + 1'b1;

    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        // dcache wins unless the icache is also asking and the dcache had the last turn.
        if (d_req && (!iREN || !last_d_q)) begin
          state_d  = DGNT;
          wd_cnt_d = '0;
        end else if (iREN) begin
          state_d  = IGNT;
          wd_cnt_d = '0;
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          // Withdrawn request: abandon without touching last_d; a coincident ACCESS is ignored.
          state_d = IDLE;
        end else if (ram_access) begin
          iwait    = 1'b0;
          iload    = ramload;
          last_d_d = 1'b0;
          state_d  = IDLE;
        end else begin
          wd_cnt_d = wd_inc;
          if (wd_inc == TIMEOUT_CNT) err_d = 1'b1;
        end
      end

      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram_access) begin
          dwait    = 1'b0;
          dload    = dWEN ? 32'd0 : ramload;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wd_cnt_d = wd_inc;
          if (wd_inc == TIMEOUT_CNT) err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the RAM port (0 nobody, 1 icache, 2 dcache),
  // whether the dcache had the last completed turn, stalled grant cycles, sticky err.
  int m_owner  = 0;
  bit m_last_d = 1'b0;
  int m_stall  = 0;
  bit m_err    = 1'b0;
  bit m_known  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven after the falling edge; check outputs
  // against the model, advance the model, then move to the next falling edge.
  task automatic tick();
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    bit          want, acc;
    #1;
    acc     = (ramstate == ACCESS);
    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_iload = '0;   e_dload = '0;   e_addr = '0;  e_store = '0;
    if (m_owner == 1) begin
      e_ren  = iREN;
      e_addr = iaddr;
      if (iREN && acc) begin e_iwait = 1'b0; e_iload = ramload; end
    end else if (m_owner == 2) begin
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_addr  = daddr;
      e_store = dstore;
      if ((dREN || dWEN) && acc) begin
        e_dwait = 1'b0;
        e_dload = dWEN ? 32'd0 : ramload;
      end
    end
    if (m_known) begin
      chk("m_iwait", iwait, e_iwait);
      chk("m_iload", iload, e_iload);
      chk("m_dwait", dwait, e_dwait);
      chk("m_dload", dload, e_dload);
      chk("m_ramREN", ramREN, e_ren);
      chk("m_ramWEN", ramWEN, e_wen);
      chk("m_ramaddr", ramaddr, e_addr);
      chk("m_ramstore", ramstore, e_store);
      chk("m_err", err, m_err);
      chk("one_wait_low", 32'(!iwait && !dwait), 32'd0);
      chk("one_strobe", 32'(ramREN && ramWEN), 32'd0);
    end
    if (RST) begin
      m_owner = 0; m_last_d = 1'b0; m_stall = 0; m_err = 1'b0; m_known = 1'b1;
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && (!iREN || !m_last_d)) begin m_owner = 2; m_stall = 0; end
      else if (iREN) begin m_owner = 1; m_stall = 0; end
    end else begin
      want = (m_owner == 1) ? iREN : (dREN || dWEN);
      if (!want) m_owner = 0;
      else if (acc) begin m_last_d = (m_owner == 2); m_owner = 0; end
      else begin
        m_stall = (m_stall < TO) ? m_stall + 1 : TO;
        if (m_stall >= TO) m_err = 1'b1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int r;
    // Reset held two cycles with both caches requesting.
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h40; daddr = 32'h200; dstore = '0; ramload = '0; ramstate = BUSY;
    tick();
    #1;
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0); chk("rst_err", err, 0);
    tick();
    RST = 1'b0;
    tick();
    #1;
    chk("first_dgnt_addr", ramaddr, 32'h200); chk("first_dgnt_ren", ramREN, 1);
    tick();
    iREN = 1'b0; dREN = 1'b0;
    tick();
    tick();

    // Icache read with three BUSY cycles.
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("icache_ren", ramREN, 1); chk("icache_wait", iwait, 1); chk("icache_addr", ramaddr, 32'h40);
      tick();
    end
    ramstate = ACCESS; ramload = 32'h8C220004;
    #1;
    chk("icache_iwait", iwait, 0); chk("icache_iload", iload, 32'h8C220004);
    tick();
    iREN = 1'b0;
    #1;
    chk("icache_idle_ren", ramREN, 0);
    tick();

    // Contention with a 0-wait RAM: D, I, D, I.
    iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS; ramload = 32'h0BADF00D;
    for (int idx = 0; idx < 8; idx++) begin
      #1;
      chk("cont_dwait", dwait, (idx % 4 == 1) ? 0 : 1);
      chk("cont_iwait", iwait, (idx % 4 == 3) ? 0 : 1);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // Write wins over read.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
    tick();
    #1;
    chk("wr_wen", ramWEN, 1); chk("wr_ren", ramREN, 0);
    chk("wr_store", ramstore, 32'hDEADBEEF); chk("wr_addr", ramaddr, 32'h100);
    ramstate = ACCESS; ramload = 32'h12345678;
    #1;
    chk("wr_dwait", dwait, 0); chk("wr_dload", dload, 0);
    tick();
    dREN = 1'b0; dWEN = 1'b0;
    tick();

    // Icache withdraws during BUSY; coincident ACCESS must be ignored.
    iREN = 1'b1; ramstate = BUSY;
    tick();
    tick();
    iREN = 1'b0; ramstate = ACCESS;
    #1;
    chk("wdraw_ren", ramREN, 0); chk("wdraw_iwait", iwait, 1);
    tick();
    iREN = 1'b1;
    #1;
    chk("wdraw_idle_ren", ramREN, 0);
    tick();
    iREN = 1'b0;
    tick();

    // Reset during a dcache grant.
    dREN = 1'b1; ramstate = BUSY;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mid_ren", ramREN, 0); chk("rst_mid_dwait", dwait, 1);
    tick();
    dREN = 1'b0;
    tick();

    // Watchdog: ERROR status keeps the grant waiting until err sets.
    iREN = 1'b1; ramstate = ERROR;
    tick();
    for (int k = 0; k < TO; k++) begin
      #1;
      chk("wdog_err_low", err, 0);
      tick();
    end
    #1;
    chk("wdog_err_high", err, 1); chk("wdog_hold", ramREN, 1);
    tick();
    ramstate = ACCESS;
    #1;
    chk("wdog_done", iwait, 0);
    tick();
    iREN = 1'b0;
    #1;
    chk("wdog_sticky", err, 1);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST     = ($urandom_range(0, 63) == 0);
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = ($urandom_range(0, 2) != 0);
      dWEN    = ($urandom_range(0, 3) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? FREE : ERROR;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that sits directly downstream of the instruction and data caches of one core. It accepts the icache fill request (iREN/iaddr) and the dcache read/write request (dREN/dWEN/daddr/dstore), grants exactly one of them at a time to the RAM port, and returns iwait/iload and dwait/dload. Arbitration is registered, alternates on contention, and a watchdog flags a RAM that never answers.

## Interface
- TIMEOUT, 1023: RAM cycles a grant may last without ACCESS before `err` sets; counter width is $clog2(TIMEOUT+1).
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset. This is fixed.
- iREN  in  1  icache fill request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- iwait  out  1  low only in the cycle the icache access completes.
- iload  out  32  instruction word, valid when iwait is low.
- dwait  out  1  low only in the cycle the dcache access completes.
- dload  out  32  data word, valid when dwait is low after a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- err  out  1  sticky watchdog flag.

## Operation
- The FSM has three states: IDLE, IGNT, DGNT. It also keeps a register `last_d`, which is 1 when the most recent completed grant went to the dcache.
- Transitions out of IDLE:
  - If a dcache request (dREN|dWEN) is pending and either iREN=0 or last_d=0, go to DGNT.
  - Otherwise, if iREN=1, go to IGNT.
  - Otherwise, stay in IDLE.
- When both caches request, grants alternate. From reset the dcache wins the first contention.
- In IGNT:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - When ramstate=ACCESS, iwait=0 and iload=ramload (combinational), last_d<=0, next state IDLE.
- In DGNT:
  - ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate=ACCESS, dwait=0 and dload=ramload (reads only; writes give dload=0). last_d<=1, next state IDLE.
- Request withdrawal: if the granted requester drops its request (iREN=0 in IGNT, dREN|dWEN=0 in DGNT), the RAM strobes drop the same cycle, the next state is IDLE, and last_d is unchanged. An ACCESS in that same cycle is ignored.
- BUSY, FREE and ERROR during a grant all mean "keep waiting": wait stays high and the state is held.
- Watchdog:
  - The counter clears on entry to a grant state and increments each grant cycle without ACCESS.
  - When it reaches TIMEOUT, `err`<=1 (sticky until RST). The grant is still held.
- Outside completion cycles: iwait=dwait=1, iload=dload=0.
- In IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Addresses and data pass through unmodified. There is no alignment check.

## Timing
- Reset state: IDLE, last_d=0, counter=0, err=0. All outputs are at their IDLE values: iwait=dwait=1, loads 0, RAM strobes 0, ramaddr/ramstore 0.
- RST asserted mid-grant: at the next edge the FSM is in IDLE and the RAM strobes drop. The in-flight access is abandoned and no wait goes low.
- Request cycle and grant cycle:
  - A request is sampled in IDLE at cycle N.
  - The RAM strobes assert in cycle N+1.
  - A 0-wait-state RAM (ACCESS in N+1) completes in N+1.
- Bubble and throughput:
  - IDLE is always re-entered for one cycle after completion.
  - The earliest next grant begins at completion+2.
  - Peak throughput is one access per 2 cycles.
- Request sampling: a request first raised during another requester's grant is only sampled in IDLE.
- Only one of iwait/dwait is ever low in a cycle. The RAM strobes are never both high.

## Test plan
- Reset: hold RST 2 cycles with iREN=dREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, err=0. First grant is DGNT (ramaddr=daddr) the cycle after RST falls.
- Icache read: iREN=1, iaddr=0x40, ramstate=ACCESS after 3 BUSY cycles, ramload=0x8C220004 -> ramREN high cycles N+1..N+4, iwait low only in N+4 with iload=0x8C220004, then IDLE.
- Contention alternation: iREN=dREN=1 held continuously, 0-wait RAM -> grant order D, I, D, I. Each wait pulses low for one cycle, every other cycle at minimum.
- Write precedence: dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; on completion dwait=0, dload=0.
- Withdrawal and reset mid-grant:
  - iREN dropped during BUSY -> RAM strobes drop the same cycle, IDLE next cycle, iwait never low.
  - RST during DGNT -> strobes 0 the next cycle.
- Watchdog: TIMEOUT=4, grant held with ramstate=ERROR -> err rises after 4 grant cycles and stays high after ACCESS completes. Only RST clears it.
